// File: rtl/lap_recorder_pkg.sv
// lap_recorder_pkg: shared state encoding, widths and reset constants for the lap recorder
package lap_recorder_pkg;
  localparam int LAP_W = 16;
  localparam int TOT_W = 20;
  localparam logic [LAP_W-1:0] BEST_INIT = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, RACING, FINISHED} state_e;
endpackage

// File: rtl/lap_recorder_if.sv
// lap_recorder_if: race control, stopwatch and lap statistics signals of the lap recorder
interface lap_recorder_if;
  import lap_recorder_pkg::*;
  logic             race_start;
  logic             lap_finished;
  logic [LAP_W-1:0] counter;
  logic             timer_start;
  logic             timer_stop;
  logic [3:0]       lap_count;
  logic [LAP_W-1:0] last_lap;
  logic [LAP_W-1:0] best_lap;
  logic [TOT_W-1:0] total_time;
  logic             new_best;
  logic             race_over;
  modport master (
    output race_start, lap_finished, counter,
    input  timer_start, timer_stop, lap_count, last_lap, best_lap, total_time, new_best, race_over
  );
  modport slave (
    input  race_start, lap_finished, counter,
    output timer_start, timer_stop, lap_count, last_lap, best_lap, total_time, new_best, race_over
  );
endinterface

// File: rtl/lap_recorder.sv
// lap_recorder: tracks laps of a race, driving the stopwatch and keeping last/best/total lap times
module lap_recorder
  import lap_recorder_pkg::*;
#(
  parameter int N_LAPS = 3
) (
  input logic           clk,
  input logic           rst,
  lap_recorder_if.slave rec
);
  localparam logic [3:0] LAST_IDX = 4'(N_LAPS - 1);
  state_e           state_q, state_d;
  logic [3:0]       lap_count_q, lap_count_d;
  logic [LAP_W-1:0] last_q, last_d;
  logic [LAP_W-1:0] best_q, best_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             new_best_q, new_best_d;
  logic             timer_start_q, timer_start_d;
  logic             timer_stop_q, timer_stop_d;
  logic             race_over_q, race_over_d;
  logic             accept, fin_lap, improve;
  // race_start restarts from any state and wins over a simultaneous lap
  always_comb begin
    accept  = state_q == RACING && rec.lap_finished && !rec.race_start;
    fin_lap = accept && lap_count_q == LAST_IDX;
    improve = accept && rec.counter < best_q;
    state_d = rec.race_start ? RACING : fin_lap ? FINISHED : state_q;
  end
  always_comb begin
    lap_count_d   = rec.race_start ? '0 : accept ? lap_count_q + 4'd1 : lap_count_q;
    last_d        = rec.race_start ? '0 : accept ? rec.counter : last_q;
    best_d        = rec.race_start ? BEST_INIT : improve ? rec.counter : best_q;
    total_d       = rec.race_start ? '0 : accept ? total_q + TOT_W'(rec.counter) : total_q;
    new_best_d    = improve;
    timer_start_d = rec.race_start;
    timer_stop_d  = fin_lap;
    race_over_d   = state_d == FINISHED;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lap_count_q   <= '0;
      last_q        <= '0;
      best_q        <= BEST_INIT;
      total_q       <= '0;
      new_best_q    <= 1'b0;
      timer_start_q <= 1'b0;
      timer_stop_q  <= 1'b0;
      race_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lap_count_q   <= lap_count_d;
      last_q        <= last_d;
      best_q        <= best_d;
      total_q       <= total_d;
      new_best_q    <= new_best_d;
      timer_start_q <= timer_start_d;
      timer_stop_q  <= timer_stop_d;
      race_over_q   <= race_over_d;
    end
  end
  assign rec.lap_count   = lap_count_q;
  assign rec.last_lap    = last_q;
  assign rec.best_lap    = best_q;
  assign rec.total_time  = total_q;
  assign rec.new_best    = new_best_q;
  assign rec.timer_start = timer_start_q;
  assign rec.timer_stop  = timer_stop_q;
  assign rec.race_over   = race_over_q;
endmodule
